pipelined_add_sub: RTL and testbench

Parametrised, pipelined signed add/subtract unit with a valid/ready handshake and status flags. It is the clocked successor to the combinational ripple-carry add/sub.
- The operand is split into slices. Each pipeline stage adds one slice and registers the carry into the next stage, so the critical path is bounded by slice width rather than full data width.
- It sits in the ALU datapath between the operand-select logic and the result writeback/flag register.

---
 rtl/pipelined_add_sub.sv | 134 +++++++++++++
 tb/tb_pipelined_add_sub.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// Pipelined signed add/subtract unit: one operand slice per stage, carry
// registered between stages, global-stall valid/ready handshake, and
// registered Sum/CarryOut/Overflow/Zero/Negative. DataLength must be an
// integer multiple of SliceWidth.
module pipelined_add_sub #(
  parameter int unsigned DataLength = 16,
  parameter int unsigned SliceWidth = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DataLength-1:0] i_augend,
  input  logic [DataLength-1:0] i_addend,
  input  logic                  i_subtract_enable,
  input  logic                  i_carry_in,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DataLength-1:0] o_sum,
  output logic                  o_carry_out,
  output logic                  o_overflow,
  output logic                  o_zero,
  output logic                  o_negative
);

  localparam int unsigned NumStages = DataLength / SliceWidth;
  localparam int unsigned LastStage = NumStages - 1;

  logic w_advance;
  logic w_msb_cin;
  logic r_overflow;
  logic r_zero;
  logic r_negative;

  // Whole pipeline moves together; it only freezes when a finished result
  // is waiting and downstream is not taking it.
  assign w_advance  = ~o_out_valid | i_out_ready;
  assign o_in_ready = w_advance;

  for (genvar k = 0; k < NumStages; k++) begin : g_stage
    // Operand bits still to be added when entering stage k, and result
    // bits already produced after stage k.
    localparam int unsigned InW  = DataLength - k * SliceWidth;
    localparam int unsigned SumW = (k + 1) * SliceWidth;

    logic [InW-1:0]      w_a_in;
    logic [InW-1:0]      w_b_in;
    logic                w_c_in;
    logic                w_valid_in;
    logic [SliceWidth:0] w_slice;
    logic [SumW-1:0]     w_s_nxt;

    logic                r_valid;
    logic [SumW-1:0]     r_s;
    logic                r_c;

    if (k == 0) begin : g_head
      // Subtraction folded in at entry as B inverted plus inverted carry-in.
      assign w_a_in     = i_augend;
      assign w_b_in     = i_addend ^ {DataLength{i_subtract_enable}};
      assign w_c_in     = i_carry_in ^ i_subtract_enable;
      assign w_valid_in = i_in_valid;
      assign w_s_nxt    = w_slice[SliceWidth-1:0];
    end else begin : g_body
      assign w_a_in     = g_stage[k-1].g_fwd.r_a;
      assign w_b_in     = g_stage[k-1].g_fwd.r_b;
      assign w_c_in     = g_stage[k-1].r_c;
      assign w_valid_in = g_stage[k-1].r_valid;
      assign w_s_nxt    = {w_slice[SliceWidth-1:0], g_stage[k-1].r_s};
    end

    // One slice of ripple add; the top bit is the carry into the next stage.
    assign w_slice = {1'b0, w_a_in[SliceWidth-1:0]}
                   + {1'b0, w_b_in[SliceWidth-1:0]}
                   + {{SliceWidth{1'b0}}, w_c_in};

    // Stage register: valid bit, partial result and slice carry.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_valid <= 1'b0;
        r_s     <= '0;
        r_c     <= 1'b0;
      end else if (w_advance) begin
        r_valid <= w_valid_in;
        r_s     <= w_s_nxt;
        r_c     <= w_slice[SliceWidth];
      end
    end

    if (k < LastStage) begin : g_fwd
      localparam int unsigned RemW = InW - SliceWidth;

      logic [RemW-1:0] r_a;
      logic [RemW-1:0] r_b;

      // Skew the not-yet-added operand slices along with the partial sum.
      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_advance) begin
          r_a <= w_a_in[InW-1:SliceWidth];
          r_b <= w_b_in[InW-1:SliceWidth];
        end
      end
    end
  end

  // Carry into the MSB recovered from the MSB sum bit and its operand bits.
  assign w_msb_cin = g_stage[LastStage].w_a_in[SliceWidth-1]
                   ^ g_stage[LastStage].w_b_in[SliceWidth-1]
                   ^ g_stage[LastStage].w_slice[SliceWidth-1];

  // Status flags registered alongside the final stage result.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
    end else if (w_advance) begin
      r_overflow <= w_msb_cin ^ g_stage[LastStage].w_slice[SliceWidth];
      r_zero     <= (g_stage[LastStage].w_s_nxt == '0);
      r_negative <= g_stage[LastStage].w_s_nxt[DataLength-1];
    end
  end

  assign o_out_valid = g_stage[LastStage].r_valid;
  assign o_sum       = g_stage[LastStage].r_s;
  assign o_carry_out = g_stage[LastStage].r_c;
  assign o_overflow  = r_overflow;
  assign o_zero      = r_zero;
  assign o_negative  = r_negative;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub (8-bit data, 4-bit slices).
module tb_pipelined_add_sub;

  localparam int unsigned DL = 8;
  localparam int unsigned SW = 4;

  typedef struct packed {
    logic [DL-1:0] sum;
    logic          co;
    logic          ov;
    logic          z;
    logic          n;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
    bit   chk;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [DL-1:0] i_augend;
  logic [DL-1:0] i_addend;
  logic          i_subtract_enable;
  logic          i_carry_in;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [DL-1:0] o_sum;
  logic          o_carry_out;
  logic          o_overflow;
  logic          o_zero;
  logic          o_negative;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  res_t mon_act;
  exp_t mon_exp;

  pipelined_add_sub #(.DataLength(DL), .SliceWidth(SW)) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_in_valid       (i_in_valid),
    .o_in_ready       (o_in_ready),
    .i_augend         (i_augend),
    .i_addend         (i_addend),
    .i_subtract_enable(i_subtract_enable),
    .i_carry_in       (i_carry_in),
    .o_out_valid      (o_out_valid),
    .i_out_ready      (i_out_ready),
    .o_sum            (o_sum),
    .o_carry_out      (o_carry_out),
    .o_overflow       (o_overflow),
    .o_zero           (o_zero),
    .o_negative       (o_negative)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output transfer pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (o_out_valid && i_out_ready) begin
      mon_act = '{sum: o_sum, co: o_carry_out, ov: o_overflow, z: o_zero, n: o_negative};
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output got sum=%h co=%b ov=%b z=%b n=%b, required no output",
                 mon_act.sum, mon_act.co, mon_act.ov, mon_act.z, mon_act.n);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp.r) begin
          fails++;
          $display("FAIL result got sum=%h co=%b ov=%b z=%b n=%b, required sum=%h co=%b ov=%b z=%b n=%b",
                   mon_act.sum, mon_act.co, mon_act.ov, mon_act.z, mon_act.n,
                   mon_exp.r.sum, mon_exp.r.co, mon_exp.r.ov, mon_exp.r.z, mon_exp.r.n);
        end
        if (mon_exp.chk) begin
          tests++;
          if (cyc - mon_exp.acc != 2) begin
            fails++;
            $display("FAIL latency got %0d cycles, required 2", cyc - mon_exp.acc);
          end
        end
      end
    end
  end

  function automatic res_t mk(input logic [DL-1:0] s, input logic co, input logic ov,
                              input logic z, input logic n);
    mk = '{sum: s, co: co, ov: ov, z: z, n: n};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h, required %h", name, act, exp);
    end
  endtask

  // Present one operand set until accepted; optionally record its expectation.
  task automatic send(input logic [DL-1:0] a, input logic [DL-1:0] b, input logic sub,
                      input logic cin, input res_t exp, input bit push, input bit chk);
    int n;
    bit rdy;
    i_in_valid        = 1'b1;
    i_augend          = a;
    i_addend          = b;
    i_subtract_enable = sub;
    i_carry_in        = cin;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = o_in_ready;
      if (rdy && push) sb.push_back('{r: exp, acc: cyc, chk: chk});
      @(posedge clk);
      #1;
      n++;
    end
    i_in_valid = 1'b0;
    if (!rdy) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout got in_ready=0 for 50 cycles, required 1");
    end
  endtask

  // Wait for every expected result to emerge, within a cycle budget.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic send_stream(input bit chk);
    send(8'h01, 8'h01, 1'b0, 1'b0, mk(8'h02, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, chk);
    send(8'h02, 8'h02, 1'b0, 1'b0, mk(8'h04, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, chk);
    send(8'h03, 8'h03, 1'b0, 1'b0, mk(8'h06, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, chk);
    send(8'h0F, 8'h01, 1'b0, 1'b0, mk(8'h10, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, chk);
  endtask

  initial begin
    rst_n             = 1'b0;
    i_in_valid        = 1'b0;
    i_augend          = '0;
    i_addend          = '0;
    i_subtract_enable = 1'b0;
    i_carry_in        = 1'b0;
    i_out_ready       = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_in_ready",  32'(o_in_ready),  32'd1);
    check("rst_sum",       32'(o_sum),       32'd0);
    check("rst_flags", 32'({o_carry_out, o_overflow, o_zero, o_negative}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed arithmetic vectors, back to back
    send(8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1, 1'b1);
    send(8'h05, 8'h05, 1'b1, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1);
    send(8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1);
    send(8'h10, 8'h01, 1'b1, 1'b1, mk(8'h0E, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1);
    send(8'h80, 8'h01, 1'b1, 1'b0, mk(8'h7F, 1'b1, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1);
    send(8'h00, 8'h00, 1'b0, 1'b1, mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1);
    send(8'h80, 8'h80, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b1, 1'b1, 1'b0), 1'b1, 1'b1);
    send(8'h3C, 8'h5A, 1'b1, 1'b0, mk(8'hE2, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1, 1'b1);
    drain();

    // Back-to-back stream, downstream always ready
    send_stream(1'b1);
    drain();

    // Same stream with a three-cycle stall after the first result appears
    fork
      send_stream(1'b0);
      begin
        int n;
        n = 0;
        while (!o_out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        i_out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready",  32'(o_in_ready),  32'd0);
          check("stall_out_valid", 32'(o_out_valid), 32'd1);
          check("stall_sum",       32'(o_sum),       32'h02);
          @(posedge clk);
          #1;
        end
        i_out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight; they must never be presented
    i_out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0, mk(8'h33, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b0, 1'b0, mk(8'h77, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    check("inflight_out_valid", 32'(o_out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(o_out_valid), 32'd0);
    check("midrst_sum",       32'(o_sum),       32'd0);
    check("midrst_in_ready",  32'(o_in_ready),  32'd1);
    check("midrst_carry",     32'(o_carry_out), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(8'h03, 8'h04, 1'b0, 1'b0, mk(8'h07, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1);
    drain();
    repeat (5) begin
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
